sd_block_reader: RTL and testbench
==================================

SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512: data bytes per block.
REQ-002 SHALL have parameter ADDR_STEP, default 512: address increment per block (512 byte-addressed, 1 for block-addressed cards).
REQ-003 SHALL have parameter RESP_TIMEOUT, default 80: maximum SCLK cycles to wait for the R1 start bit or the data token.
REQ-004 SHALL have parameter MAX_RETRY, default 3: command reissues allowed per block after a bad R1 or a timeout.
REQ-005 SHALL have parameter COUNT_WIDTH, default 8: width of the block count.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- SCLK, in, 1: the single clock, also the SPI clock; MISO sampled and MOSI driven on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: begin a transfer; honoured only in IDLE.
- start_address, in, 32: first card address; latched when start is accepted.
- block_count, in, COUNT_WIDTH: number of blocks; latched when start is accepted.
- MISO, in, 1: card data out.
- MOSI, out, 1: card data in.
- CS, out, 1: card chip select, active low.
- fifo_empty, in, 1: downstream FIFO is empty.
- fifo_data_in, out, 8: byte to the FIFO.
- fifo_push, out, 1: one-cycle write strobe.
- busy, out, 1: high whenever state is not IDLE.
- done, out, 1: level, all blocks read.
- error, out, 1: level, transfer aborted.
- err_code, out, 2: 01 = R1 nonzero, 10 = R1 timeout, 11 = token timeout.
- blocks_done, out, COUNT_WIDTH: number of blocks completed.

Function
REQ-007 SHALL implement these states: IDLE, WAIT_FIFO, SEND_CMD, WAIT_R1, GET_R1, WAIT_TOKEN, DATA, CRC, NEXT, DONE, ERROR.
REQ-008 IDLE: on start=1, SHALL latch the inputs, clear blocks_done, done, error and err_code, then go to WAIT_FIFO; if block_count=0, SHALL go directly to DONE.
REQ-009 WAIT_FIFO: SHALL stay until fifo_empty=1, then go to SEND_CMD.
REQ-010 SEND_CMD: SHALL shift 48 bits MSB-first on MOSI, one per cycle: 0x51, the 32-bit current address, then 0xFF; then go to WAIT_R1.
REQ-011 MOSI SHALL be 1 in every state other than SEND_CMD.
REQ-012 CS SHALL be 0 in WAIT_FIFO through NEXT, and 1 in IDLE, DONE and ERROR.
REQ-013 WAIT_R1: the first MISO=0 SHALL be taken as R1 bit 7 and the state SHALL go to GET_R1; after RESP_TIMEOUT cycles without it, the block is a timeout.
REQ-014 GET_R1: SHALL sample 7 further bits. R1=0x00 SHALL go to WAIT_TOKEN; any nonzero R1 is a failure.
REQ-015 WAIT_TOKEN: SHALL shift MISO into an 8-bit window; a window of 0xFE SHALL go to DATA; RESP_TIMEOUT cycles without it is a token timeout.
REQ-016 DATA: SHALL sample BLOCK_BYTES*8 bits MSB-first; after each 8th bit, fifo_data_in SHALL hold the byte and fifo_push SHALL pulse for exactly one cycle.
REQ-017 fifo_push SHALL pulse exactly BLOCK_BYTES times per block, never outside DATA or its final cycle, and fifo_data_in SHALL stay stable until the next push.
REQ-018 CRC: SHALL discard 16 bits, then go to NEXT.
REQ-019 NEXT: SHALL do the following in one cycle: address += ADDR_STEP (32-bit, wrapping modulo 2^32), blocks_done += 1, and clear the retry counter. If blocks_done equals block_count, it SHALL go to DONE; otherwise to WAIT_FIFO.
REQ-020 On a failure or timeout with retries < MAX_RETRY, SHALL increment retries and return to SEND_CMD at the same address; otherwise SHALL go to ERROR with err_code set.
REQ-021 DONE and ERROR: SHALL hold their outputs; start=1 SHALL return to IDLE and be accepted there on a later cycle.
REQ-022 start while busy SHALL be ignored.
REQ-023 Changes to start_address or block_count after acceptance SHALL have no effect on the transfer in progress.

Reset
REQ-024 reset_n=0 at a rising SCLK edge SHALL force IDLE, CS=1, MOSI=1, fifo_push=0, busy=0, done=0, error=0, err_code=00, blocks_done=0, retries=0, address=0.
REQ-025 reset_n=0 mid-DATA SHALL abort the transfer with no further fifo_push from the next cycle on.

Verification
REQ-026 Card model, start_address=0x0000_1000, block_count=2, R1=0x00 after 3 cycles, token after 10 cycles -> the two commands carry 0x51 00 00 10 00 FF and 0x51 00 00 12 00 FF; 1024 pushes with data matching the model; done=1; blocks_done=2.
REQ-027 R1=0x04 on every attempt -> 4 commands issued (1 + MAX_RETRY), then error=1, err_code=01, blocks_done=0, no pushes.
REQ-028 MISO held at 1 after the command -> WAIT_R1 times out at 80 cycles; after retries, err_code=10; CS=1 in ERROR.
REQ-029 fifo_empty=0 for 200 cycles before block 2 -> no command on MOSI during the wait; the command starts within 1 cycle of fifo_empty rising.
REQ-030 block_count=0 -> done=1 with no MOSI activity. Separately, reset_n pulsed at data byte 100 -> IDLE the next cycle and no further pushes.

Source files
------------

// File: rtl/sd_block_reader.sv
// sd_block_reader: SPI-mode SD multi-block reader built from repeated single
// block reads (CMD17). Each block waits for an empty downstream FIFO, sends
// the command, collects R1 and the data token, streams the block bytes into
// the FIFO, discards the CRC and moves to the next address. A bad R1 or a
// timeout reissues the command at the same address until the retry budget is
// exhausted.
//
// Ports:
//   SCLK          in   single clock, also the SPI clock (MISO sampled, MOSI driven on rise)
//   reset_n       in   synchronous active-low reset
//   start         in   begin a transfer (honoured in IDLE; leaves DONE/ERROR)
//   start_address in   first card address, latched on start acceptance
//   block_count   in   number of blocks, latched on start acceptance
//   MISO          in   card data out
//   MOSI          out  card data in (idle high)
//   CS            out  card chip select, active low
//   fifo_empty    in   downstream FIFO empty
//   fifo_data_in  out  byte to the FIFO
//   fifo_push     out  one-cycle FIFO write strobe
//   busy          out  high whenever not IDLE
//   done          out  level, all blocks read
//   error         out  level, transfer aborted
//   err_code      out  01 R1 nonzero, 10 R1 timeout, 11 token timeout
//   blocks_done   out  blocks completed
module sd_block_reader #(
  parameter int unsigned BLOCK_BYTES  = 512,
  parameter int unsigned ADDR_STEP    = 512,
  parameter int unsigned RESP_TIMEOUT = 80,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned COUNT_WIDTH  = 8
) (
  input  logic                   SCLK,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            start_address,
  input  logic [COUNT_WIDTH-1:0] block_count,
  input  logic                   MISO,
  output logic                   MOSI,
  output logic                   CS,
  input  logic                   fifo_empty,
  output logic [7:0]             fifo_data_in,
  output logic                   fifo_push,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [COUNT_WIDTH-1:0] blocks_done
);

  localparam int unsigned BYTE_W  = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned WAIT_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE, WAIT_FIFO, SEND_CMD, WAIT_R1, GET_R1, WAIT_TOKEN,
    DATA, CRC, NEXT, DONE, ERROR
  } state_t;

  state_t                 state;
  logic [31:0]            address;
  logic [COUNT_WIDTH-1:0] count_l;
  logic [46:0]            cmd_sr;
  logic [5:0]             bit_cnt;
  logic [BYTE_W-1:0]      byte_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [RETRY_W-1:0]     retries;
  logic [7:0]             shift;

  logic [47:0]            cmd_word;
  logic [7:0]             shift_next;
  logic [COUNT_WIDTH-1:0] blocks_next;
  logic                   retry_ok;
  logic                   fail;
  logic [1:0]             fail_code;

  always_comb begin
    cmd_word    = {8'h51, address, 8'hFF};
    shift_next  = {shift[6:0], MISO};
    blocks_next = blocks_done + COUNT_WIDTH'(1);
    retry_ok    = retries < RETRY_W'(MAX_RETRY);
    fail        = 1'b0;
    fail_code   = 2'b00;
    case (state)
      WAIT_R1: if (MISO && wait_cnt == WAIT_W'(RESP_TIMEOUT - 1)) begin
        fail      = 1'b1;
        fail_code = 2'b10;
      end
      GET_R1: if (bit_cnt == 6'd6 && shift_next != 8'h00) begin
        fail      = 1'b1;
        fail_code = 2'b01;
      end
      WAIT_TOKEN: if (shift_next != 8'hFE && wait_cnt == WAIT_W'(RESP_TIMEOUT - 1)) begin
        fail      = 1'b1;
        fail_code = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      state        <= IDLE;
      address      <= '0;
      count_l      <= '0;
      cmd_sr       <= '1;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      retries      <= '0;
      shift        <= '1;
      MOSI         <= 1'b1;
      CS           <= 1'b1;
      fifo_data_in <= '0;
      fifo_push    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
      blocks_done  <= '0;
    end else begin
      fifo_push <= 1'b0;
      case (state)
        IDLE: if (start) begin
          address     <= start_address;
          count_l     <= block_count;
          blocks_done <= '0;
          retries     <= '0;
          done        <= 1'b0;
          error       <= 1'b0;
          err_code    <= 2'b00;
          busy        <= 1'b1;
          if (block_count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WAIT_FIFO;
            CS    <= 1'b0;
          end
        end
        WAIT_FIFO: if (fifo_empty) begin
          state   <= SEND_CMD;
          cmd_sr  <= cmd_word[46:0];
          MOSI    <= cmd_word[47];
          bit_cnt <= '0;
        end
        SEND_CMD: begin
          if (bit_cnt == 6'd47) begin
            state    <= WAIT_R1;
            MOSI     <= 1'b1;
            wait_cnt <= '0;
          end else begin
            MOSI    <= cmd_sr[46];
            cmd_sr  <= {cmd_sr[45:0], 1'b1};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        WAIT_R1: begin
          if (!MISO) begin
            state   <= GET_R1;
            shift   <= 8'h00;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        GET_R1: begin
          shift   <= shift_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd6 && shift_next == 8'h00) begin
            state    <= WAIT_TOKEN;
            shift    <= 8'hFF;
            wait_cnt <= '0;
          end
        end
        WAIT_TOKEN: begin
          shift <= shift_next;
          if (shift_next == 8'hFE) begin
            state    <= DATA;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DATA: begin
          shift <= shift_next;
          if (bit_cnt == 6'd7) begin
            fifo_data_in <= shift_next;
            fifo_push    <= 1'b1;
            bit_cnt      <= '0;
            if (byte_cnt == BYTE_W'(BLOCK_BYTES - 1)) state <= CRC;
            else byte_cnt <= byte_cnt + BYTE_W'(1);
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        CRC: begin
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd15) state <= NEXT;
        end
        NEXT: begin
          address     <= address + 32'(ADDR_STEP);
          blocks_done <= blocks_next;
          retries     <= '0;
          if (blocks_next == count_l) begin
            state <= DONE;
            done  <= 1'b1;
            CS    <= 1'b1;
          end else begin
            state <= WAIT_FIFO;
          end
        end
        DONE, ERROR: if (start) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Failure handling shared by WAIT_R1, GET_R1 and WAIT_TOKEN; placed
      // after the case so it overrides whatever the state branch scheduled.
      if (fail) begin
        if (retry_ok) begin
          retries <= retries + RETRY_W'(1);
          state   <= SEND_CMD;
          cmd_sr  <= cmd_word[46:0];
          MOSI    <= cmd_word[47];
          bit_cnt <= '0;
        end else begin
          state    <= ERROR;
          error    <= 1'b1;
          err_code <= fail_code;
          CS       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
module tb_sd_block_reader;
  localparam int BB = 512;
  localparam int RT = 80;
  localparam int MR = 3;
  localparam int CW = 8;

  logic          SCLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_address = '0;
  logic [CW-1:0] block_count = '0;
  logic          MISO = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          MOSI, CS, fifo_push, busy, done, error;
  logic [7:0]    fifo_data_in;
  logic [1:0]    err_code;
  logic [CW-1:0] blocks_done;

  int checks = 0;
  int failures = 0;
  int push_count = 0;
  logic [7:0] push_q[$];

  logic [47:0] c;
  logic        found;
  int          polls;

  sd_block_reader #(
    .BLOCK_BYTES(BB), .ADDR_STEP(512), .RESP_TIMEOUT(RT),
    .MAX_RETRY(MR), .COUNT_WIDTH(CW)
  ) dut (
    .SCLK(SCLK), .reset_n(reset_n), .start(start), .start_address(start_address),
    .block_count(block_count), .MISO(MISO), .MOSI(MOSI), .CS(CS),
    .fifo_empty(fifo_empty), .fifo_data_in(fifo_data_in), .fifo_push(fifo_push),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .blocks_done(blocks_done)
  );

  initial forever #5 SCLK = ~SCLK;

  always @(negedge SCLK) begin
    if (fifo_push === 1'b1) begin
      push_q.push_back(fifo_data_in);
      push_count++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] card_byte(input int blk, input int j);
    int v;
    v = j * 5 + blk * 29 + 3 + (j >> 4);
    return v[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    MISO = 1'b1;
    fifo_empty = 1'b1;
    tick(3);
    reset_n = 1'b1;
    push_q.delete();
    push_count = 0;
  endtask

  task automatic pulse_start(input logic [31:0] addr, input logic [CW-1:0] cnt);
    start_address = addr;
    block_count = cnt;
    start = 1'b1;
    @(negedge SCLK);
    start = 1'b0;
  endtask

  task automatic capture_cmd(output logic [47:0] cmd);
    cmd = '0;
    for (int i = 46; i >= 0; i--) begin
      @(negedge SCLK);
      cmd[i] = MOSI;
    end
  endtask

  task automatic wait_cmd(input int limit, output logic f, output int p, output logic [47:0] cmd);
    f = 1'b0;
    p = 0;
    cmd = '1;
    while (!f && p < limit) begin
      @(negedge SCLK);
      MISO = 1'b1;
      p++;
      if (MOSI === 1'b0) f = 1'b1;
    end
    if (f) capture_cmd(cmd);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge SCLK);
      MISO = b[i];
    end
  endtask

  task automatic send_ones(input int n);
    repeat (n) begin
      @(negedge SCLK);
      MISO = 1'b1;
    end
  endtask

  // R1 after 3 idle bits, token after 10 idle bits, full block, 16 CRC bits.
  task automatic send_block(input int blk);
    send_ones(3);
    send_byte(8'h00);
    send_ones(10);
    send_byte(8'hFE);
    for (int j = 0; j < BB; j++) send_byte(card_byte(blk, j));
    send_byte(8'hA5);
    send_byte(8'h3C);
    @(negedge SCLK);
    MISO = 1'b1;
  endtask

  task automatic check_data(input string name, input int nbytes);
    int bad;
    bad = 0;
    for (int i = 0; i < push_q.size(); i++)
      if (push_q[i] !== card_byte(i / BB, i % BB)) bad++;
    if (push_q.size() != nbytes) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d bad bytes out of %0d pushed, required 0 bad of %0d", name, bad, push_q.size(), nbytes);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({CS, MOSI, fifo_push, busy, done, error, err_code} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 11000000", {CS, MOSI, fifo_push, busy, done, error, err_code});
    end
    checks++;
    if (blocks_done !== '0) begin
      failures++;
      $display("FAIL reset_blocks_done: got %0d required 0", blocks_done);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_two_blocks();
    do_reset();
    pulse_start(32'h0000_1000, 8'd2);
    start_address = 32'hDEAD_0000;
    block_count = 8'd5;
    checks++;
    if ({busy, CS} !== 2'b10) begin
      failures++;
      $display("FAIL two_accept: busy,CS got %b required 10", {busy, CS});
    end
    wait_cmd(20, found, polls, c);
    checks++;
    if (!found || c !== 48'h51_0000_1000_FF) begin
      failures++;
      $display("FAIL two_cmd1: got %h required 510000_1000FF (found=%0d)", c, found);
    end
    // start while busy must be ignored
    start_address = 32'h0BAD_0000;
    block_count = 8'd7;
    start = 1'b1;
    @(negedge SCLK);
    start = 1'b0;
    send_block(0);
    wait_cmd(20, found, polls, c);
    checks++;
    if (!found || c !== 48'h51_0000_1200_FF) begin
      failures++;
      $display("FAIL two_cmd2: got %h required 510000_1200FF (found=%0d)", c, found);
    end
    checks++;
    if (push_count != BB) begin
      failures++;
      $display("FAIL two_push_blk0: got %0d required %0d", push_count, BB);
    end
    send_block(1);
    tick(4);
    checks++;
    if ({done, error, CS} !== 3'b101 || blocks_done !== 8'd2) begin
      failures++;
      $display("FAIL two_done: done,error,CS got %b blocks_done %0d required 101 and 2", {done, error, CS}, blocks_done);
    end
    checks++;
    if (push_count != 2 * BB) begin
      failures++;
      $display("FAIL two_push_total: got %0d required %0d", push_count, 2 * BB);
    end
    check_data("two_data", 2 * BB);
  endtask

  task automatic test_r1_error();
    do_reset();
    pulse_start(32'h0000_0040, 8'd1);
    for (int a = 0; a <= MR; a++) begin
      wait_cmd(100, found, polls, c);
      checks++;
      if (!found || c !== 48'h51_0000_0040_FF) begin
        failures++;
        $display("FAIL r1err_cmd%0d: got %h required 5100000040FF (found=%0d)", a, c, found);
      end
      send_ones(3);
      send_byte(8'h04);
    end
    wait_cmd(60, found, polls, c);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL r1err_extra_cmd: got a command %h required none", c);
    end
    checks++;
    if ({error, done, CS, err_code} !== 5'b10101 || blocks_done !== '0) begin
      failures++;
      $display("FAIL r1err_status: error,done,CS,err_code got %b blocks_done %0d required 10101 and 0", {error, done, CS, err_code}, blocks_done);
    end
    checks++;
    if (push_count != 0) begin
      failures++;
      $display("FAIL r1err_push: got %0d required 0", push_count);
    end
  endtask

  task automatic test_r1_timeout();
    int n;
    do_reset();
    pulse_start(32'h0000_2000, 8'd1);
    wait_cmd(100, found, polls, c);
    for (int a = 1; a <= MR; a++) begin
      wait_cmd(200, found, polls, c);
      checks++;
      if (!found || polls != RT + 1 || c !== 48'h51_0000_2000_FF) begin
        failures++;
        $display("FAIL r1to_retry%0d: gap %0d cmd %h required gap %0d cmd 5100002000FF", a, polls, c, RT + 1);
      end
    end
    n = 0;
    while (error !== 1'b1 && n < 200) begin
      @(negedge SCLK);
      n++;
    end
    checks++;
    if (n != RT + 1) begin
      failures++;
      $display("FAIL r1to_error_time: got %0d cycles required %0d", n, RT + 1);
    end
    checks++;
    if ({err_code, CS, busy, done} !== 5'b10110 || push_count != 0) begin
      failures++;
      $display("FAIL r1to_status: err_code,CS,busy,done got %b pushes %0d required 10110 and 0", {err_code, CS, busy, done}, push_count);
    end
  endtask

  task automatic test_fifo_wait();
    int bad;
    do_reset();
    pulse_start(32'h0000_0000, 8'd2);
    wait_cmd(20, found, polls, c);
    checks++;
    if (!found || c !== 48'h51_0000_0000_FF) begin
      failures++;
      $display("FAIL fifo_cmd1: got %h required 5100000000FF", c);
    end
    fifo_empty = 1'b0;
    send_block(0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge SCLK);
      if (MOSI !== 1'b1 || CS !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fifo_hold: %0d cycles with MOSI low or CS high, required 0", bad);
    end
    fifo_empty = 1'b1;
    @(negedge SCLK);
    checks++;
    if (MOSI !== 1'b0) begin
      failures++;
      $display("FAIL fifo_cmd_start: MOSI got %b required 0 one cycle after fifo_empty", MOSI);
    end
    capture_cmd(c);
    checks++;
    if (c !== 48'h51_0000_0200_FF) begin
      failures++;
      $display("FAIL fifo_cmd2: got %h required 5100000200FF", c);
    end
    send_block(1);
    tick(4);
    checks++;
    if (done !== 1'b1 || blocks_done !== 8'd2 || push_count != 2 * BB) begin
      failures++;
      $display("FAIL fifo_done: done %b blocks_done %0d pushes %0d required 1, 2, %0d", done, blocks_done, push_count, 2 * BB);
    end
    check_data("fifo_data", 2 * BB);
  endtask

  task automatic test_zero_count();
    int bad;
    do_reset();
    pulse_start(32'h0000_3000, 8'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge SCLK);
      if (MOSI !== 1'b1 || CS !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL zero_lines: %0d cycles with MOSI or CS low, required 0", bad);
    end
    checks++;
    if ({done, error, busy} !== 3'b101 || blocks_done !== '0) begin
      failures++;
      $display("FAIL zero_status: done,error,busy got %b blocks_done %0d required 101 and 0", {done, error, busy}, blocks_done);
    end
    pulse_start(32'h0000_3000, 8'd0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_to_idle: busy got %b required 0", busy);
    end
    pulse_start(32'h0000_3000, 8'd0);
    checks++;
    if ({busy, done} !== 2'b11) begin
      failures++;
      $display("FAIL zero_restart: busy,done got %b required 11", {busy, done});
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] b;
    do_reset();
    pulse_start(32'h0000_4000, 8'd1);
    wait_cmd(20, found, polls, c);
    send_ones(3);
    send_byte(8'h00);
    send_ones(10);
    send_byte(8'hFE);
    for (int j = 0; j < 100; j++) send_byte(card_byte(0, j));
    b = card_byte(0, 100);
    for (int i = 7; i >= 5; i--) begin
      @(negedge SCLK);
      MISO = b[i];
    end
    @(negedge SCLK);
    MISO = b[4];
    reset_n = 1'b0;
    @(negedge SCLK);
    checks++;
    if ({busy, CS, fifo_push} !== 3'b010 || push_count != 100) begin
      failures++;
      $display("FAIL rst_mid_idle: busy,CS,push got %b pushes %0d required 010 and 100", {busy, CS, fifo_push}, push_count);
    end
    reset_n = 1'b1;
    for (int j = 101; j < 110; j++) send_byte(card_byte(0, j));
    checks++;
    if (push_count != 100 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_nopush: pushes %0d busy %b required 100 and 0", push_count, busy);
    end
    check_data("rst_mid_data", 100);
  endtask

  initial begin
    test_reset();
    test_two_blocks();
    test_r1_error();
    test_r1_timeout();
    test_fifo_wait();
    test_zero_count();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
